// File: rtl/alu_acc.sv
// alu_acc: accumulator ALU with registered flags, a valid/ready input
// handshake and a multi-cycle shift-add multiplier. ALU_Out is the accumulator.
module alu_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             err
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ACC  = 4'b1010;
  localparam logic [3:0] OP_CLR  = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_PASS = 4'b1101;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       alu_out_q, alu_out_d;
  logic                   zero_q, zero_d;
  logic                   carry_q, carry_d;
  logic                   neg_q, neg_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  // Single-cycle datapath intermediates (widened by one bit to expose carry/borrow)
  logic [WIDTH:0]         add_full, sub_full, acc_full, shl_ext, shr_ext;
  logic                   big_shift;
  logic [2*WIDTH-1:0]     mul_addend, prod_next;

  // Decoded result of a single-cycle op
  logic [WIDTH-1:0]       res;      // value written to the accumulator
  logic [WIDTH-1:0]       fval;     // value that zero/negative are derived from
  logic                   res_c, res_v, res_wr, res_rsvd, res_mul;

  assign add_full  = {1'b0, A} + {1'b0, B};
  assign sub_full  = {1'b0, A} - {1'b0, B};
  assign acc_full  = {1'b0, alu_out_q} + {1'b0, A};
  // The extra bit catches the last bit shifted out in either direction
  assign shl_ext   = {1'b0, A} << B;
  assign shr_ext   = {A, 1'b0} >> B;
  assign big_shift = ({1'b0, B} >= (WIDTH+1)'(WIDTH));

  // One shift-add step: add A<<i into the product when bit i of B is set
  assign mul_addend = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
  assign prod_next  = prod_q + mul_addend;

  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign ALU_Out   = alu_out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign err       = err_q;

  // Opcode decode: result, flag sources and write-back enable for one-cycle ops
  always_comb begin
    res      = alu_out_q;
    fval     = alu_out_q;
    res_c    = 1'b0;
    res_v    = 1'b0;
    res_wr   = 1'b1;
    res_rsvd = 1'b0;
    res_mul  = 1'b0;
    case (opcode)
      OP_ADD: begin
        res   = add_full[MSB:0];
        res_c = add_full[WIDTH];
        res_v = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res    = sub_full[MSB:0];
        res_c  = sub_full[WIDTH];
        res_v  = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
        res_wr = (opcode == OP_SUB);
      end
      OP_MUL:  res_mul = 1'b1;
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_NOT:  res = ~A;
      OP_SHL: begin
        res   = big_shift ? '0 : shl_ext[MSB:0];
        res_c = big_shift ? 1'b0 : shl_ext[WIDTH];
      end
      OP_SHR: begin
        res   = big_shift ? '0 : shr_ext[WIDTH:1];
        res_c = big_shift ? 1'b0 : shr_ext[0];
      end
      OP_ACC: begin
        res   = acc_full[MSB:0];
        res_c = acc_full[WIDTH];
        res_v = (alu_out_q[MSB] == A[MSB]) && (acc_full[MSB] != alu_out_q[MSB]);
      end
      OP_CLR:  res = '0;
      OP_PASS: res = A;
      default: begin
        res_rsvd = 1'b1;
        res_wr   = 1'b0;
      end
    endcase
    // CMP reports flags of A-B without touching the accumulator
    fval = (opcode == OP_CMP) ? sub_full[MSB:0] : res;
  end

  // FSM next state plus accumulator/flag write-back on completion
  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (res_mul) begin
            state_d = S_MUL;
            a_d     = A;
            b_d     = B;
            prod_d  = '0;
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            if (res_rsvd) begin
              err_d = 1'b1;
            end else begin
              err_d   = 1'b0;
              zero_d  = (fval == '0);
              neg_d   = fval[MSB];
              carry_d = res_c;
              ovf_d   = res_v;
              if (res_wr) alu_out_d = res;
            end
          end
        end
      end
      S_MUL: begin
        prod_d = prod_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = prod_next[MSB:0];
          zero_d      = (prod_next[MSB:0] == '0);
          neg_d       = prod_next[MSB];
          carry_d     = |prod_next[2*WIDTH-1:WIDTH];
          ovf_d       = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed and randomized checks of alu_acc against an
// arithmetic reference model of the accumulator and flags.
module tb_alu_acc;

  localparam int W = 8;
  localparam longint MASK = (longint'(1) << W) - 1;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic [W-1:0] ALU_Out;
  logic         zero, carry, negative, overflow, err;

  int total = 0;
  int bad = 0;

  // Reference model state
  longint m_acc = 0;
  bit m_z = 0, m_c = 0, m_n = 0, m_v = 0, m_err = 0;

  alu_acc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .A(A), .B(B), .out_valid(out_valid), .ALU_Out(ALU_Out),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v > MAXS) ? v - (MASK + 1) : v;
  endfunction

  function automatic bit ovf(input longint x);
    return (x > MAXS) || (x < MINS);
  endfunction

  // Reference: result and flags computed from the operation's arithmetic meaning
  task automatic model_apply(input logic [3:0] op, input longint a, input longint b);
    longint full, fv;
    bit c, v, wr;
    full = 0; c = 0; v = 0; wr = 1;
    case (op)
      4'b0000: begin full = a + b; c = full > MASK; v = ovf(sgn(a) + sgn(b)); end
      4'b0001: begin full = a - b; c = a < b; v = ovf(sgn(a) - sgn(b)); end
      4'b1100: begin full = a - b; c = a < b; v = ovf(sgn(a) - sgn(b)); wr = 0; end
      4'b0010: begin full = a * b; c = full > MASK; end
      4'b0100: full = a & b;
      4'b0101: full = a | b;
      4'b0110: full = a ^ b;
      4'b0111: full = ~a;
      4'b1000: if (b < W) begin
                 full = a << b;
                 c = (b != 0) && (((a >> (W - b)) & 1) == 1);
               end
      4'b1001: if (b < W) begin
                 full = a >> b;
                 c = (b != 0) && (((a >> (b - 1)) & 1) == 1);
               end
      4'b1010: begin full = m_acc + a; c = full > MASK; v = ovf(sgn(m_acc) + sgn(a)); end
      4'b1011: full = 0;
      4'b1101: full = a;
      default: begin m_err = 1; return; end
    endcase
    fv = full & MASK;
    m_err = 0;
    m_z = (fv == 0);
    m_n = ((fv >> (W - 1)) & 1) == 1;
    m_c = c;
    m_v = v;
    if (wr) m_acc = fv;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".alu"}, ALU_Out, m_acc);
    chk({tag, ".zero"}, zero, m_z);
    chk({tag, ".carry"}, carry, m_c);
    chk({tag, ".neg"}, negative, m_n);
    chk({tag, ".ovf"}, overflow, m_v);
    chk({tag, ".err"}, err, m_err);
  endtask

  // Issue one operation and check the completion cycle (and MUL busy cycles)
  task automatic apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (op == 4'b0010) begin
      chk("mul.busy_ready", in_ready, 1'b0);
      chk("mul.busy_valid", out_valid, 1'b0);
      for (int k = 1; k < W; k++) begin
        in_valid = 1'($urandom_range(0, 1));
        opcode = 4'($urandom);
        A = W'($urandom);
        B = W'($urandom);
        @(posedge clk); #1;
        chk("mul.busy_ready", in_ready, 1'b0);
        chk("mul.busy_valid", out_valid, 1'b0);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    model_apply(op, longint'(a), longint'(b));
    chk("done.valid", out_valid, 1'b1);
    chk("done.ready", in_ready, 1'b1);
    check_state("done");
    $display("op=%b a=%0h b=%0h -> out=%0h z=%0b c=%0b n=%0b v=%0b err=%0b",
             op, a, b, ALU_Out, zero, carry, negative, overflow, err);
  endtask

  // One cycle with no request: pulse must drop and state must hold
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle.valid", out_valid, 1'b0);
    chk("idle.ready", in_ready, 1'b1);
    check_state("idle");
  endtask

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", in_ready, 1'b0);
    chk("rst.valid", out_valid, 1'b0);
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", in_ready, 1'b1);

    // Directed cases
    apply(4'b0000, 8'h01, 8'h01);  chk("add11", ALU_Out, 8'h02);
    idle();
    apply(4'b0000, 8'hFF, 8'h01);  chk("addff.z", zero, 1'b1); chk("addff.c", carry, 1'b1);
    apply(4'b0000, 8'h7F, 8'h01);  chk("add7f", ALU_Out, 8'h80); chk("add7f.v", overflow, 1'b1);
    apply(4'b0010, 8'd15, 8'd17);  chk("mul15x17", ALU_Out, 8'hFF); chk("mul15x17.c", carry, 1'b0);
    apply(4'b0010, 8'd16, 8'd16);  chk("mul16x16.c", carry, 1'b1); chk("mul16x16.z", zero, 1'b1);
    apply(4'b1011, 8'h33, 8'h44);
    apply(4'b1010, 8'd5, 8'd0);    chk("acc1", ALU_Out, 8'd5);
    apply(4'b1010, 8'd5, 8'd0);    chk("acc2", ALU_Out, 8'd10);
    apply(4'b1010, 8'd5, 8'd0);    chk("acc3", ALU_Out, 8'd15);
    apply(4'b1100, 8'd3, 8'd5);    chk("cmp.alu", ALU_Out, 8'd15); chk("cmp.c", carry, 1'b1);
    apply(4'b1000, 8'h81, 8'd1);   chk("shl", ALU_Out, 8'h02); chk("shl.c", carry, 1'b1);
    apply(4'b1001, 8'h81, 8'd9);   chk("shr9", ALU_Out, 8'h00); chk("shr9.c", carry, 1'b0);
    apply(4'b1101, 8'h5A, 8'd0);
    apply(4'b1111, 8'h12, 8'h34);  chk("rsvd.err", err, 1'b1); chk("rsvd.alu", ALU_Out, 8'h5A);
    idle();
    apply(4'b0111, 8'h0F, 8'd0);   chk("not.err", err, 1'b0);

    // Randomized operations against the model
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = (rop == 4'b1000 || rop == 4'b1001) ? W'($urandom_range(0, 11)) : W'($urandom);
      apply(rop, ra, rb);
      if ($urandom_range(0, 7) == 0) idle();
    end

    // Asynchronous reset in the middle of a multiply
    apply(4'b1101, 8'hA5, 8'd0);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'b0010; A = 8'd7; B = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_acc = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_err = 0;
    chk("arst.ready", in_ready, 1'b0);
    chk("arst.valid", out_valid, 1'b0);
    check_state("arst");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("arst.hold_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst.rel_ready", in_ready, 1'b1);
    apply(4'b0000, 8'd2, 8'd3);    chk("add23", ALU_Out, 8'd5);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
